// File: rtl/fc_argmax_classifier.sv
// Argmax stage after the fully connected layer: tracks best and second-best
// class score per frame and publishes digit, score and confidence margin.
module fc_argmax_classifier #(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned IDX_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [11:0]      data_in,
    input  logic             clear,
    output logic [IDX_W-1:0] digit_out,
    output logic [11:0]      score_out,
    output logic [11:0]      margin_out,
    output logic             valid_out,
    output logic             busy,
    output logic [7:0]       frame_cnt
);

    localparam int unsigned DATA_W = 12;
    localparam int unsigned CNT_W  = 8;
    localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(NUM_CLASSES - 1);
    localparam logic signed [DATA_W-1:0] MIN_SCORE = 12'sh800;

    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [DATA_W-1:0] best_q, best_d;
    logic signed [DATA_W-1:0] second_q, second_d;
    logic [IDX_W-1:0]         best_idx_q, best_idx_d;

    logic [IDX_W-1:0]  digit_d;
    logic [DATA_W-1:0] score_d;
    logic [DATA_W-1:0] margin_d;
    logic              valid_d;
    logic              busy_d;
    logic [CNT_W-1:0]  frame_cnt_d;

    logic signed [DATA_W-1:0] score_c;
    logic signed [DATA_W-1:0] fin_best_c;
    logic signed [DATA_W-1:0] fin_second_c;
    logic [IDX_W-1:0]         fin_idx_c;
    logic [DATA_W-1:0]        fin_margin_c;

    // Running state updated with the current beat
    always_comb begin
        score_c      = $signed(data_in);
        fin_best_c   = best_q;
        fin_second_c = second_q;
        fin_idx_c    = best_idx_q;
        if (idx_q == '0) begin
            fin_best_c   = score_c;
            fin_second_c = MIN_SCORE;
            fin_idx_c    = '0;
        end else if (score_c > best_q) begin
            fin_second_c = best_q;
            fin_best_c   = score_c;
            fin_idx_c    = idx_q;
        end else if (score_c > second_q) begin
            fin_second_c = score_c;
        end
        // best >= second always, so the 13-bit difference fits in 12 bits unsigned
        fin_margin_c = DATA_W'(fin_best_c - fin_second_c);
    end

    // Next-state and published-output logic
    always_comb begin
        idx_d       = idx_q;
        best_d      = best_q;
        second_d    = second_q;
        best_idx_d  = best_idx_q;
        digit_d     = digit_out;
        score_d     = score_out;
        margin_d    = margin_out;
        valid_d     = 1'b0;
        frame_cnt_d = frame_cnt;

        if (clear) begin
            idx_d      = '0;
            best_d     = '0;
            second_d   = MIN_SCORE;
            best_idx_d = '0;
        end else if (valid_in) begin
            best_d     = fin_best_c;
            second_d   = fin_second_c;
            best_idx_d = fin_idx_c;
            if (idx_q == LAST_IDX) begin
                idx_d       = '0;
                digit_d     = fin_idx_c;
                score_d     = fin_best_c;
                margin_d    = fin_margin_c;
                valid_d     = 1'b1;
                frame_cnt_d = frame_cnt + CNT_W'(1);
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        busy_d = (idx_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            best_q     <= '0;
            second_q   <= MIN_SCORE;
            best_idx_q <= '0;
            digit_out  <= '0;
            score_out  <= '0;
            margin_out <= '0;
            valid_out  <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            idx_q      <= idx_d;
            best_q     <= best_d;
            second_q   <= second_d;
            best_idx_q <= best_idx_d;
            digit_out  <= digit_d;
            score_out  <= score_d;
            margin_out <= margin_d;
            valid_out  <= valid_d;
            busy       <= busy_d;
            frame_cnt  <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// Directed bench for fc_argmax_classifier with hand-computed frame results.
module tb_fc_argmax_classifier;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [11:0] data_in;
    logic        clear;
    logic [3:0]  digit_out;
    logic [11:0] score_out;
    logic [11:0] margin_out;
    logic        valid_out;
    logic        busy;
    logic [7:0]  frame_cnt;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int exp_frames = 0;
    int p0;
    logic [11:0] f [10];

    fc_argmax_classifier #(.NUM_CLASSES(10), .IDX_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
        .clear(clear), .digit_out(digit_out), .score_out(score_out),
        .margin_out(margin_out), .valid_out(valid_out), .busy(busy),
        .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (valid_out) pulses <= pulses + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the sampling edge
    task automatic send(input logic [11:0] v);
        valid_in = 1'b1;
        data_in  = v;
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input int maxgap);
        for (int i = lo; i <= hi; i++) begin
            if (maxgap > 0 && i != lo) repeat ($urandom_range(0, maxgap)) @(negedge clk);
            send(f[i]);
        end
    endtask

    task automatic check_result(input string tag, input logic [3:0] d,
                                input logic [11:0] s, input logic [11:0] m);
        exp_frames++;
        check({tag, "_valid"}, 32'(valid_out), 32'd1);
        check({tag, "_digit"}, 32'(digit_out), 32'(d));
        check({tag, "_score"}, 32'(score_out), 32'(s));
        check({tag, "_margin"}, 32'(margin_out), 32'(m));
        check({tag, "_fcnt"}, 32'(frame_cnt), 32'(exp_frames));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_digit"}, 32'(digit_out), 32'd0);
        check({tag, "_score"}, 32'(score_out), 32'd0);
        check({tag, "_margin"}, 32'(margin_out), 32'd0);
        check({tag, "_valid"}, 32'(valid_out), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_fcnt"}, 32'(frame_cnt), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; data_in = '0; clear = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame: max 900 at class 3, runner-up 899
        f = '{12'(0), 12'(10), 12'(20), 12'(900), 12'(30), 12'(-5), 12'(899), 12'(1), 12'(2), 12'(3)};
        p0 = pulses;
        send_range(0, 4, 0);
        check("a_busy_mid", 32'(busy), 32'd1);
        send_range(5, 9, 0);
        check_result("a", 4'd3, 12'd900, 12'd1);
        @(negedge clk);
        check("a_valid_drop", 32'(valid_out), 32'd0);
        check("a_busy_after", 32'(busy), 32'd0);
        check("a_pulses", 32'(pulses - p0), 32'd1);

        // All minimum scores, then all ties
        for (int i = 0; i < 10; i++) f[i] = 12'h800;
        send_range(0, 9, 0);
        check_result("min", 4'd0, 12'h800, 12'd0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) f[i] = 12'd5;
        send_range(0, 9, 0);
        check_result("tie", 4'd0, 12'd5, 12'd0);
        @(negedge clk);

        // Full-range margin, then a back-to-back frame
        for (int i = 0; i < 9; i++) f[i] = 12'h800;
        f[9] = 12'd2047;
        p0 = pulses;
        send_range(0, 9, 0);
        check_result("maxm", 4'd9, 12'd2047, 12'd4095);
        for (int i = 0; i < 10; i++) f[i] = 12'd0;
        f[0] = 12'd100;
        send_range(0, 0, 0);
        check("b2b_valid_drop", 32'(valid_out), 32'd0);
        check("b2b_hold_digit", 32'(digit_out), 32'd9);
        send_range(1, 9, 0);
        check_result("b2b", 4'd0, 12'd100, 12'd100);
        @(negedge clk);
        check("b2b_pulses", 32'(pulses - p0), 32'd2);

        // Partial frame aborted by clear (with a simultaneous beat)
        p0 = pulses;
        for (int i = 0; i < 5; i++) send(12'd1000);
        clear = 1'b1; valid_in = 1'b1; data_in = 12'd2000;
        @(negedge clk);
        clear = 1'b0; valid_in = 1'b0;
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_hold_fcnt", 32'(frame_cnt), 32'(exp_frames));
        check("clr_hold_margin", 32'(margin_out), 32'd100);
        f = '{12'(0), 12'(0), 12'(0), 12'(250), 12'(0), 12'(0), 12'(0), 12'(300), 12'(0), 12'(0)};
        send_range(0, 9, 0);
        check_result("clr", 4'd7, 12'd300, 12'd50);
        @(negedge clk);
        check("clr_pulses", 32'(pulses - p0), 32'd1);

        // Random idle gaps between beats
        f = '{12'(10), 12'(20), 12'(30), 12'(40), 12'(123), 12'(-50), 12'(100), 12'(0), 12'(5), 12'(6)};
        p0 = pulses;
        send_range(0, 8, 5);
        repeat (3) @(negedge clk);
        check("gap_no_midpulse", 32'(pulses - p0), 32'd0);
        check("gap_busy", 32'(busy), 32'd1);
        send_range(9, 9, 0);
        check_result("gap", 4'd4, 12'd123, 12'd23);
        @(negedge clk);
        check("gap_pulses", 32'(pulses - p0), 32'd1);

        // Reset mid-frame
        for (int i = 0; i < 6; i++) send(12'd1500);
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_frames = 0;
        f = '{12'(0), 12'(0), 12'(77), 12'(70), 12'(1), 12'(2), 12'(3), 12'(4), 12'(5), 12'(6)};
        send_range(0, 9, 0);
        check_result("post_rst", 4'd2, 12'd77, 12'd7);
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
